// File: rtl/qadd_rr_scheduler.sv
// Round-robin front end that shares one sign-magnitude adder among NREQ requesters.
// Each sum is registered into a single output slot and tagged with its requester ID and an overflow flag.
module qadd_rr_scheduler #(
    parameter int N    = 32,
    parameter int Q    = 15,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [N-1:0]        res_data,
    output logic [IDW-1:0]      res_id,
    output logic                res_ovf,
    output logic [CNTW-1:0]     ovf_cnt,
    input  logic                ovf_clr
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    // Parameter sanity: the ID must cover every requester and the binary point must lie inside the word.
    if ((NREQ < 2) || (NREQ > 8) || ((1 << IDW) < NREQ) || (Q >= N)) begin : g_param_err
        $error("qadd_rr_scheduler: illegal parameter combination");
    end

    // Returns {carry, sum}; -0 is kept for like signs and exact cancellation yields +0.
    function automatic logic [N:0] qadd_f(input logic [N-1:0] a, input logic [N-1:0] b);
        logic          sa;
        logic          sb;
        logic [N-2:0]  ma;
        logic [N-2:0]  mb;
        logic [N-1:0]  sum_w;
        sa    = a[N-1];
        sb    = b[N-1];
        ma    = a[N-2:0];
        mb    = b[N-2:0];
        sum_w = {1'b0, ma} + {1'b0, mb};
        if (sa == sb) begin
            qadd_f = {sum_w[N-1], sa, sum_w[N-2:0]};
        end else if (ma > mb) begin
            qadd_f = {1'b0, sa, ma - mb};
        end else if (mb > ma) begin
            qadd_f = {1'b0, sb, mb - ma};
        end else begin
            qadd_f = {(N+1){1'b0}};
        end
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDW-1:0]    r_ptr;
    logic [N-1:0]      r_data;
    logic [IDW-1:0]    r_id;
    logic              r_ovf;
    logic [CNTW-1:0]   r_ovf_cnt;

    logic              w_any;
    logic [IDW-1:0]    w_gnt_id;
    logic              w_can_load;
    logic              w_grant;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [N-1:0]      w_a;
    logic [N-1:0]      w_b;
    logic [N:0]        w_sum;
    logic              w_out_xfer;

    // Rotating priority search starting at the pointer; the first valid requester wins.
    always_comb begin : p_search
        int  idx;
        logic hit;
        idx      = 0;
        hit      = 1'b0;
        w_any    = 1'b0;
        w_gnt_id = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx      = (int'(r_ptr) + k) % NREQ;
            hit      = !w_any && req_valid[idx];
            w_gnt_id = hit ? IDW'(idx) : w_gnt_id;
            w_any    = w_any | hit;
        end
    end

    // The slot can take a new result when empty or when its current one leaves this cycle.
    assign w_can_load = (r_state == S_FULL) ? res_ready : 1'b1;
    assign w_grant    = w_can_load && w_any && rst_n;
    assign w_ptr_nxt  = (int'(w_gnt_id) == NREQ - 1) ? {IDW{1'b0}} : (w_gnt_id + IDW'(1));
    assign w_a        = req_a[int'(w_gnt_id)*N +: N];
    assign w_b        = req_b[int'(w_gnt_id)*N +: N];
    assign w_sum      = qadd_f(w_a, w_b);
    assign w_out_xfer = (r_state == S_FULL) && res_ready;

    // One-hot grant to the selected requester.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (w_grant) begin
            req_ready = NREQ'(1) << w_gnt_id;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Slot next-state: a grant always fills it, an accept without a grant drains it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: w_state_nxt = w_grant ? S_FULL : S_EMPTY;
            S_FULL: begin
                if (res_ready) begin
                    w_state_nxt = w_grant ? S_FULL : S_EMPTY;
                end else begin
                    w_state_nxt = S_FULL;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result slot and round-robin pointer, both advanced only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= {IDW{1'b0}};
            r_data <= {N{1'b0}};
            r_id   <= {IDW{1'b0}};
            r_ovf  <= 1'b0;
        end else if (w_grant) begin
            r_ptr  <= w_ptr_nxt;
            r_data <= w_sum[N-1:0];
            r_id   <= w_gnt_id;
            r_ovf  <= w_sum[N];
        end else begin
            r_ptr  <= r_ptr;
            r_data <= r_data;
            r_id   <= r_id;
            r_ovf  <= r_ovf;
        end
    end

    // Saturating count of overflowed results as they are accepted; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= {CNTW{1'b0}};
        end else if (ovf_clr) begin
            r_ovf_cnt <= {CNTW{1'b0}};
        end else if (w_out_xfer && r_ovf && (r_ovf_cnt != {CNTW{1'b1}})) begin
            r_ovf_cnt <= r_ovf_cnt + CNTW'(1);
        end else begin
            r_ovf_cnt <= r_ovf_cnt;
        end
    end

    assign res_valid = (r_state == S_FULL);
    assign res_data  = r_data;
    assign res_id    = r_id;
    assign res_ovf   = r_ovf;
    assign ovf_cnt   = r_ovf_cnt;

endmodule
